pixel_compositor: RTL and testbench

Pipelined, parametrised successor to the combinational colour mapper. Composites maze walls, pellets, Pac-Man and N ghosts into one 24-bit VGA pixel per clock with fixed 2-cycle latency. Adds a frame-counted frightened-mode state machine: ghosts turn blue, then blink, and eaten ghosts are hidden. Sits between the maze/sprite position logic and the VGA output pins.

---
 rtl/pixel_compositor.sv | 268 ++++++++++++++++++++++++++
 tb/tb_pixel_compositor.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_compositor.sv
// pixel_compositor: two-stage pixel compositor for the maze display.
//   Stage 1 registers the hit flags for one pixel: wall edge, pellet dot,
//   Pac-Man and the per-ghost hits (eaten ghosts already masked out).
//   Stage 2 resolves priority and registers the 24-bit colour.
//   A frame-counted NORMAL/FRIGHT/BLINK machine recolours the ghosts after
//   a power pellet is eaten.
// Ports:
//   Clk, Reset_n          pixel clock, async active-low reset
//   frame_tick            one-cycle pulse at frame start
//   fright_start          one-cycle pulse, power pellet eaten
//   ghost_eaten[N]        per-ghost hide mask
//   pix_valid_in          DrawX/DrawY are in the active region
//   DrawX, DrawY          pixel coordinates
//   is_wall, is_pellet    tile class at the pixel
//   adjacent_walls_vga    edge select per side: [0]=up [1]=right [2]=down [3]=left
//   pacman_x/y, ghost_x/y sprite tile origins
//   fright_active         FSM is in FRIGHT or BLINK
//   pix_valid_out         pix_valid_in delayed by 2
//   VGA_R/G/B             pixel colour
// Optional: define POWER_PELLET_EN to add the is_power_pellet input and a
//   blinking power-pellet dot.

module sprite_hit #(
  parameter int BODY_LO = 3,
  parameter int BODY_HI = 13
) (
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  input  logic [9:0] org_x,
  input  logic [9:0] org_y,
  output logic       hit
);
  localparam logic [10:0] LO = 11'(BODY_LO);
  localparam logic [10:0] HI = 11'(BODY_HI);

  // 11-bit sums so an origin near 1023 cannot wrap into a false hit
  logic [10:0] dx, dy, ox, oy;
  assign dx = {1'b0, draw_x};
  assign dy = {1'b0, draw_y};
  assign ox = {1'b0, org_x};
  assign oy = {1'b0, org_y};

  assign hit = (dx >= ox + LO) && (dx < ox + HI) &&
               (dy >= oy + LO) && (dy < oy + HI);
endmodule

module pixel_compositor #(
  parameter int N_GHOSTS      = 4,
  parameter int BODY_LO       = 3,
  parameter int BODY_HI       = 13,
  parameter int WALL_THICK    = 2,
  parameter int FRIGHT_FRAMES = 360,
  parameter int BLINK_FRAMES  = 120,
  parameter int BLINK_HALF    = 8
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      frame_tick,
  input  logic                      fright_start,
  input  logic [N_GHOSTS-1:0]       ghost_eaten,
  input  logic                      pix_valid_in,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic                      is_wall,
  input  logic                      is_pellet,
  input  logic [3:0]                adjacent_walls_vga,
`ifdef POWER_PELLET_EN
  input  logic                      is_power_pellet,
`endif
  input  logic [9:0]                pacman_x,
  input  logic [9:0]                pacman_y,
  input  logic [N_GHOSTS-1:0][9:0]  ghost_x,
  input  logic [N_GHOSTS-1:0][9:0]  ghost_y,
  output logic                      fright_active,
  output logic                      pix_valid_out,
  output logic [7:0]                VGA_R,
  output logic [7:0]                VGA_G,
  output logic [7:0]                VGA_B
);
  localparam int STAGES = 2;
  localparam int CW     = $clog2(FRIGHT_FRAMES + 1);
  localparam int BW     = $clog2(BLINK_HALF + 1);

  localparam logic [CW-1:0] BLINK_AT  = CW'(FRIGHT_FRAMES - BLINK_FRAMES);
  localparam logic [CW-1:0] FRIGHT_END = CW'(FRIGHT_FRAMES);
  localparam logic [BW-1:0] HALF      = BW'(BLINK_HALF);
  localparam logic [3:0]    WT_LO     = 4'(WALL_THICK);
  localparam logic [3:0]    WT_HI     = 4'(15 - WALL_THICK);

  localparam logic [23:0] C_PAC    = 24'hFFEE00;
  localparam logic [23:0] C_WHITE  = 24'hFFFFFF;
  localparam logic [23:0] C_WALL   = 24'h1919A6;
  localparam logic [23:0] C_FRIGHT = 24'h2121FF;
  localparam logic [3:0][23:0] PAL = {24'hDB851C, 24'hD03E19, 24'h46BFEE, 24'hEA82E5};

  typedef enum logic [1:0] {NORMAL, FRIGHT, BLINK} state_t;

  // ---------------- frightened-mode FSM ----------------
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (fright_start) begin
      // restart the full duration; a coincident tick is dropped
      state_d = FRIGHT;
      cnt_d   = '0;
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (frame_tick) begin
      case (state_q)
        FRIGHT: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == BLINK_AT) begin
            state_d = BLINK;
            bcnt_d  = '0;
          end
        end
        BLINK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == FRIGHT_END) begin
            state_d = NORMAL;
            cnt_d   = '0;
            bcnt_d  = '0;
            phase_d = 1'b0;
          end else begin
            // separate half-period counter avoids a modulo on frame_cnt
            bcnt_d = bcnt_q + 1'b1;
            if (bcnt_d == HALF) begin
              bcnt_d  = '0;
              phase_d = ~phase_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign fright_active = (state_q != NORMAL);

  // ---------------- stage 1: hit tests ----------------
  logic [3:0] x_off, y_off;
  assign x_off = DrawX[3:0];
  assign y_off = DrawY[3:0];

  logic                wall_hit, pel_hit, pac_hit;
  logic [N_GHOSTS-1:0] ghost_hit;

  assign wall_hit = is_wall &
                    ((adjacent_walls_vga[0] & (y_off < WT_LO)) |
                     (adjacent_walls_vga[1] & (x_off > WT_HI)) |
                     (adjacent_walls_vga[2] & (y_off > WT_HI)) |
                     (adjacent_walls_vga[3] & (x_off < WT_LO)));

  logic dot_hit;
  assign dot_hit = ~is_wall & is_pellet &
                   (x_off >= 4'd6) & (x_off <= 4'd9) &
                   (y_off >= 4'd6) & (y_off <= 4'd9);

`ifdef POWER_PELLET_EN
  // free-running frame counter; bit 4 gives a 32-frame blink
  logic [4:0] frame_free;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)        frame_free <= '0;
    else if (frame_tick) frame_free <= frame_free + 1'b1;
  end

  logic pp_hit;
  assign pp_hit  = ~is_wall & is_power_pellet & ~frame_free[4] &
                   (x_off >= 4'd4) & (x_off <= 4'd11) &
                   (y_off >= 4'd4) & (y_off <= 4'd11);
  assign pel_hit = dot_hit | pp_hit;
`else
  assign pel_hit = dot_hit;
`endif

  sprite_hit #(.BODY_LO(BODY_LO), .BODY_HI(BODY_HI)) u_pac (
    .draw_x(DrawX), .draw_y(DrawY), .org_x(pacman_x), .org_y(pacman_y), .hit(pac_hit)
  );

  logic [N_GHOSTS-1:0] ghost_raw;
  for (genvar g = 0; g < N_GHOSTS; g++) begin : g_ghost
    sprite_hit #(.BODY_LO(BODY_LO), .BODY_HI(BODY_HI)) u_hit (
      .draw_x(DrawX), .draw_y(DrawY), .org_x(ghost_x[g]), .org_y(ghost_y[g]),
      .hit(ghost_raw[g])
    );
  end
  // an eaten ghost is dropped before priority so the pixel falls through
  assign ghost_hit = ghost_raw & ~ghost_eaten;

  logic                s1_wall, s1_pel, s1_pac;
  logic [N_GHOSTS-1:0] s1_ghost;
  logic [STAGES:1]     vld_pipe;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_wall  <= 1'b0;
      s1_pel   <= 1'b0;
      s1_pac   <= 1'b0;
      s1_ghost <= '0;
      vld_pipe <= '0;
    end else begin
      s1_wall  <= wall_hit;
      s1_pel   <= pel_hit;
      s1_pac   <= pac_hit;
      s1_ghost <= ghost_hit;
      vld_pipe <= {vld_pipe[STAGES-1:1], pix_valid_in};
    end
  end

  // ---------------- stage 2: priority + colour ----------------
  logic        g_any;
  logic [1:0]  g_pal;
  logic [23:0] rgb_d, rgb_q;

  always_comb begin
    g_any = 1'b0;
    g_pal = 2'd0;
    // ascending scan: the highest hit index is the last one written
    for (int i = 0; i < N_GHOSTS; i++) begin
      if (s1_ghost[i]) begin
        g_any = 1'b1;
        g_pal = 2'(i);
      end
    end

    rgb_d = 24'h000000;
    if (vld_pipe[1]) begin
      if (g_any) begin
        case (state_q)
          FRIGHT:  rgb_d = C_FRIGHT;
          BLINK:   rgb_d = phase_q ? C_WHITE : C_FRIGHT;
          default: rgb_d = PAL[g_pal];
        endcase
      end else if (s1_pac)  rgb_d = C_PAC;
      else if (s1_pel)      rgb_d = C_WHITE;
      else if (s1_wall)     rgb_d = C_WALL;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) rgb_q <= '0;
    else          rgb_q <= rgb_d;
  end

  assign {VGA_R, VGA_G, VGA_B} = rgb_q;
  assign pix_valid_out         = vld_pipe[STAGES];
endmodule

// File: tb/tb_pixel_compositor.sv
// Bench for pixel_compositor: directed vector table, multi-cycle sequences
// for latency, reset and the frightened-mode timing, and randomized pixels
// checked against a frame-arithmetic reference model.
module tb_pixel_compositor;
  localparam int NG = 4;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic                 Reset_n, frame_tick, fright_start, pix_valid_in;
  logic [NG-1:0]        ghost_eaten;
  logic [9:0]           DrawX, DrawY, pacman_x, pacman_y;
  logic                 is_wall, is_pellet;
  logic [3:0]           adjacent_walls_vga;
  logic [NG-1:0][9:0]   ghost_x, ghost_y;
  logic                 fright_active, pix_valid_out;
  logic [7:0]           VGA_R, VGA_G, VGA_B;
`ifdef POWER_PELLET_EN
  logic                 is_power_pellet = 1'b0;
`endif

  pixel_compositor #(.N_GHOSTS(NG)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .fright_start(fright_start),
    .ghost_eaten(ghost_eaten), .pix_valid_in(pix_valid_in), .DrawX(DrawX), .DrawY(DrawY),
    .is_wall(is_wall), .is_pellet(is_pellet), .adjacent_walls_vga(adjacent_walls_vga),
`ifdef POWER_PELLET_EN
    .is_power_pellet(is_power_pellet),
`endif
    .pacman_x(pacman_x), .pacman_y(pacman_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .fright_active(fright_active), .pix_valid_out(pix_valid_out),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  typedef struct {
    logic          v;
    logic [9:0]    dx, dy;
    logic          wall, pel;
    logic [3:0]    adj;
    logic [9:0]    px, py;
    logic [NG-1:0][9:0] gx, gy;
    logic [NG-1:0] eaten;
  } pix_t;

  typedef struct {
    pix_t        p;
    logic [23:0] rgb;
    logic        vo;
  } vec_t;

  int n_vec = 0, n_err = 0;
  // reference mode: frames elapsed since the last power pellet
  bit fr_on = 0;
  int fr_frames = 0;
  logic [23:0] expq[$];
  logic        vq[$];
  string       nmq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic pix_t mkp(int dx, int dy);
    pix_t p;
    p.v = 1'b1; p.dx = 10'(dx); p.dy = 10'(dy);
    p.wall = 1'b0; p.pel = 1'b0; p.adj = 4'b0000;
    p.px = 10'd900; p.py = 10'd900;
    for (int g = 0; g < NG; g++) begin p.gx[g] = 10'd900; p.gy[g] = 10'd900; end
    p.eaten = '0;
    return p;
  endfunction

  function automatic vec_t mkv(pix_t p, logic [23:0] rgb, logic vo);
    vec_t v;
    v.p = p; v.rgb = rgb; v.vo = vo;
    return v;
  endfunction

  function automatic bit in_spr(logic [9:0] o, logic [9:0] d);
    int oi = int'(o);
    int di = int'(d);
    return (di >= oi + 3) && (di < oi + 13);
  endfunction

  // colour from the rules, using the frame count directly for the mode
  function automatic logic [23:0] model(pix_t p);
    logic [23:0] pal[4];
    int xo, yo;
    pal[0] = 24'hEA82E5; pal[1] = 24'h46BFEE; pal[2] = 24'hD03E19; pal[3] = 24'hDB851C;
    xo = int'(p.dx) % 16;
    yo = int'(p.dy) % 16;
    if (!p.v) return 24'h0;
    for (int g = NG - 1; g >= 0; g--) begin
      if (!p.eaten[g] && in_spr(p.gx[g], p.dx) && in_spr(p.gy[g], p.dy)) begin
        if (!fr_on) return pal[g % 4];
        if (fr_frames < 240) return 24'h2121FF;
        return (((fr_frames - 240) / 8) % 2 == 1) ? 24'hFFFFFF : 24'h2121FF;
      end
    end
    if (in_spr(p.px, p.dx) && in_spr(p.py, p.dy)) return 24'hFFEE00;
    if (!p.wall && p.pel && xo >= 6 && xo <= 9 && yo >= 6 && yo <= 9) return 24'hFFFFFF;
    if (p.wall && ((p.adj[0] && yo < 2) || (p.adj[1] && xo > 13) ||
                   (p.adj[2] && yo > 13) || (p.adj[3] && xo < 2))) return 24'h1919A6;
    return 24'h0;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply(input pix_t p);
    pix_valid_in = p.v; DrawX = p.dx; DrawY = p.dy;
    is_wall = p.wall; is_pellet = p.pel; adjacent_walls_vga = p.adj;
    pacman_x = p.px; pacman_y = p.py;
    ghost_x = p.gx; ghost_y = p.gy; ghost_eaten = p.eaten;
  endtask

  // one pixel per clock; each output is checked two edges after presentation
  task automatic push_cycle(input pix_t p, input logic [23:0] e, input logic ev, input string nm);
    apply(p);
    expq.push_back(e); vq.push_back(ev); nmq.push_back(nm);
    step();
    if (expq.size() == 2) begin
      chk(nmq[0], {VGA_R, VGA_G, VGA_B}, expq[0]);
      chk({nmq[0], "_vld"}, pix_valid_out, vq[0]);
      void'(expq.pop_front()); void'(vq.pop_front()); void'(nmq.pop_front());
    end
  endtask

  task automatic drain();
    pix_valid_in = 1'b0;
    step();
    if (expq.size() == 1) begin
      chk(nmq[0], {VGA_R, VGA_G, VGA_B}, expq[0]);
      chk({nmq[0], "_vld"}, pix_valid_out, vq[0]);
    end
    expq.delete(); vq.delete(); nmq.delete();
  endtask

  task automatic one_px(input pix_t p, input logic [23:0] e, input string nm);
    push_cycle(p, e, p.v, nm);
    drain();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      pix_valid_in = 1'b0; frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      if (fr_on) begin
        fr_frames++;
        if (fr_frames == 360) fr_on = 0;
      end
    end
  endtask

  task automatic fstart(input logic with_tick);
    pix_valid_in = 1'b0; fright_start = 1'b1; frame_tick = with_tick;
    step();
    fright_start = 1'b0; frame_tick = 1'b0;
    fr_on = 1; fr_frames = 0;
  endtask

  function automatic logic [9:0] near(logic [9:0] d);
    if ($urandom_range(0, 3) == 0) return 10'($urandom_range(0, 1023));
    return 10'((int'(d) + 1024 - int'($urandom_range(0, 15))) % 1024);
  endfunction

  task automatic rand_batch(input int n, input string tag);
    pix_t p;
    for (int i = 0; i < n; i++) begin
      p = mkp($urandom_range(0, 1023), $urandom_range(0, 1023));
      p.v = ($urandom_range(0, 7) != 0);
      p.wall = $urandom_range(0, 1) == 1;
      p.pel = $urandom_range(0, 1) == 1;
      p.adj = 4'($urandom_range(0, 15));
      p.px = near(p.dx); p.py = near(p.dy);
      for (int g = 0; g < NG; g++) begin p.gx[g] = near(p.dx); p.gy[g] = near(p.dy); end
      p.eaten = ($urandom_range(0, 1) == 1) ? NG'($urandom_range(0, 15)) : '0;
      push_cycle(p, model(p), p.v, $sformatf("%s_%0d", tag, i));
    end
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    pix_t p;

    Reset_n = 1'b0; frame_tick = 1'b0; fright_start = 1'b0;
    apply(mkp(0, 0)); pix_valid_in = 1'b0;
    step(); step();
    chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
    chk("rst_vld", pix_valid_out, 1'b0);
    chk("rst_fright", fright_active, 1'b0);
    @(negedge Clk); Reset_n = 1'b1;
    step();

    // first-pixel latency: nothing after one edge, result after two
    p = mkp(40, 40); p.px = 10'd32; p.py = 10'd32;
    apply(p);
    step();
    chk("lat1_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
    chk("lat1_vld", pix_valid_out, 1'b0);
    pix_valid_in = 1'b0;
    step();
    chk("lat2_rgb", {VGA_R, VGA_G, VGA_B}, 24'hFFEE00);
    chk("lat2_vld", pix_valid_out, 1'b1);
    step();
    chk("lat3_vld", pix_valid_out, 1'b0);

    // ---- directed vector table (NORMAL mode) ----
    p = mkp(40, 40); p.px = 10'd32; p.py = 10'd32;                   tbl.push_back(mkv(p, 24'hFFEE00, 1));
    p = mkp(35, 35); p.px = 10'd32; p.py = 10'd32; p.gx[1] = 10'd32; p.gy[1] = 10'd32;
                                                                     tbl.push_back(mkv(p, 24'h46BFEE, 1));
    p.eaten = 4'b0010;                                               tbl.push_back(mkv(p, 24'hFFEE00, 1));
    p = mkp(36, 36);
    for (int g = 0; g < NG; g++) begin p.gx[g] = 10'd32; p.gy[g] = 10'd32; end
                                                                     tbl.push_back(mkv(p, 24'hDB851C, 1));
    p.eaten = 4'b1000;                                               tbl.push_back(mkv(p, 24'hD03E19, 1));
    p.eaten = 4'b1110;                                               tbl.push_back(mkv(p, 24'hEA82E5, 1));
    p = mkp(16, 17); p.wall = 1; p.adj = 4'b0001;                    tbl.push_back(mkv(p, 24'h1919A6, 1));
    p = mkp(16, 18); p.wall = 1; p.adj = 4'b0001;                    tbl.push_back(mkv(p, 24'h000000, 1));
    p = mkp(14, 5);  p.wall = 1; p.adj = 4'b0010;                    tbl.push_back(mkv(p, 24'h1919A6, 1));
    p = mkp(13, 5);  p.wall = 1; p.adj = 4'b0010;                    tbl.push_back(mkv(p, 24'h000000, 1));
    p = mkp(5, 14);  p.wall = 1; p.adj = 4'b0100;                    tbl.push_back(mkv(p, 24'h1919A6, 1));
    p = mkp(1, 5);   p.wall = 1; p.adj = 4'b1000;                    tbl.push_back(mkv(p, 24'h1919A6, 1));
    p = mkp(2, 5);   p.wall = 1; p.adj = 4'b1000;                    tbl.push_back(mkv(p, 24'h000000, 1));
    p = mkp(7, 7);   p.pel = 1;                                      tbl.push_back(mkv(p, 24'hFFFFFF, 1));
    p = mkp(6, 9);   p.pel = 1;                                      tbl.push_back(mkv(p, 24'hFFFFFF, 1));
    p = mkp(10, 7);  p.pel = 1;                                      tbl.push_back(mkv(p, 24'h000000, 1));
    p = mkp(7, 7);   p.pel = 1; p.wall = 1;                          tbl.push_back(mkv(p, 24'h000000, 1));
    p = mkp(7, 7);   p.pel = 1; p.px = 10'd0; p.py = 10'd0;          tbl.push_back(mkv(p, 24'hFFEE00, 1));
    p = mkp(34, 40); p.px = 10'd32; p.py = 10'd32;                   tbl.push_back(mkv(p, 24'h000000, 1));
    p = mkp(35, 40); p.px = 10'd32; p.py = 10'd32;                   tbl.push_back(mkv(p, 24'hFFEE00, 1));
    p = mkp(44, 44); p.px = 10'd32; p.py = 10'd32;                   tbl.push_back(mkv(p, 24'hFFEE00, 1));
    p = mkp(45, 40); p.px = 10'd32; p.py = 10'd32;                   tbl.push_back(mkv(p, 24'h000000, 1));
    p = mkp(1023, 1023); p.px = 10'd1015; p.py = 10'd1015;           tbl.push_back(mkv(p, 24'hFFEE00, 1));
    p = mkp(3, 3);   p.px = 10'd1020; p.py = 10'd1020;               tbl.push_back(mkv(p, 24'h000000, 1));
    p = mkp(40, 40); p.px = 10'd32; p.py = 10'd32; p.v = 0;          tbl.push_back(mkv(p, 24'h000000, 0));
    p.v = 1;                                                         tbl.push_back(mkv(p, 24'hFFEE00, 1));

    for (int i = 0; i < tbl.size(); i++)
      push_cycle(tbl[i].p, tbl[i].rgb, tbl[i].vo, $sformatf("tbl%0d", i));
    drain();

    // ---- frightened-mode timing ----
    p = mkp(35, 35); p.gx[1] = 10'd32; p.gy[1] = 10'd32;
    fstart(1'b0);
    chk("fr_active0", fright_active, 1'b1);
    ticks(240);
    one_px(p, 24'h2121FF, "fr_blue");
    chk("fr_active1", fright_active, 1'b1);
    ticks(8);
    one_px(p, 24'hFFFFFF, "blink_white");
    ticks(8);
    one_px(p, 24'h2121FF, "blink_blue");
    ticks(104);
    one_px(p, 24'h46BFEE, "fr_end");
    chk("fr_active_end", fright_active, 1'b0);

    // re-trigger with a coincident tick at frame 300 restarts from zero
    fstart(1'b0);
    ticks(300);
    fstart(1'b1);
    ticks(247);
    one_px(p, 24'h2121FF, "retrig_blue");
    chk("retrig_active", fright_active, 1'b1);
    ticks(1);
    one_px(p, 24'hFFFFFF, "retrig_white");
    ticks(112);
    one_px(p, 24'h46BFEE, "retrig_end");

    // ---- randomized pixels across mode points ----
    rand_batch(50, "rnd_norm");
    fstart(1'b0); ticks(100);
    rand_batch(50, "rnd_fright");
    ticks(150);
    rand_batch(50, "rnd_blink1");
    ticks(10);
    rand_batch(50, "rnd_blink0");
    ticks(100);
    rand_batch(50, "rnd_after");

    // ---- mid-frame reset clears the pipeline and the mode ----
    fstart(1'b0);
    p = mkp(40, 40); p.px = 10'd32; p.py = 10'd32;
    apply(p);
    step();
    pix_valid_in = 1'b0;
    step();
    chk("mid_pre_rgb", {VGA_R, VGA_G, VGA_B}, 24'hFFEE00);
    Reset_n = 1'b0;
    #1;
    fr_on = 0; fr_frames = 0;
    chk("mid_rst_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
    chk("mid_rst_vld", pix_valid_out, 1'b0);
    chk("mid_rst_fright", fright_active, 1'b0);
    @(negedge Clk); Reset_n = 1'b1;
    apply(p);
    step();
    chk("mid_rel1_vld", pix_valid_out, 1'b0);
    pix_valid_in = 1'b0;
    step();
    chk("mid_rel2_rgb", {VGA_R, VGA_G, VGA_B}, 24'hFFEE00);
    chk("mid_rel2_vld", pix_valid_out, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
